// File: rtl/tug_playfield_if.sv
// Key inputs and display/score outputs of the tug-of-war playfield.
interface tug_playfield_if #(
    parameter int NUM_LIGHTS = 9
);
    logic                  L;
    logic                  R;
    logic [NUM_LIGHTS-1:0] lights;
    logic [3:0]            left_score;
    logic [3:0]            right_score;
    logic                  round_win_l;
    logic                  round_win_r;
    logic                  match_over;
    logic                  match_winner;

    modport master (
        output L, R,
        input  lights, left_score, right_score,
        input  round_win_l, round_win_r, match_over, match_winner
    );

    modport slave (
        input  L, R,
        output lights, left_score, right_score,
        output round_win_l, round_win_r, match_over, match_winner
    );
endinterface

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: one-hot light row, press edge detection, scoring, match end.
// Optional macro TUG_END_FLASH_EN: flash the winner's end light during ROUND_END/MATCH_OVER.
module tug_playfield #(
    parameter int NUM_LIGHTS  = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    tug_playfield_if.slave pf
);
    localparam int C  = (NUM_LIGHTS - 1) / 2;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [NUM_LIGHTS-1:0] RIGHT_END = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
    localparam logic [NUM_LIGHTS-1:0] LEFT_END  = {1'b1, {(NUM_LIGHTS-1){1'b0}}};
    localparam logic [NUM_LIGHTS-1:0] CENTRE    = RIGHT_END << C;
    localparam logic [3:0]            WIN       = 4'(WIN_SCORE);
    localparam logic [CW-1:0]         HOLD_LAST = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] S_PLAY       = 2'd0;
    localparam logic [1:0] S_ROUND_END  = 2'd1;
    localparam logic [1:0] S_MATCH_OVER = 2'd2;

    logic [1:0]            state;
    logic [NUM_LIGHTS-1:0] lights_q;
    logic [3:0]            left_q;
    logic [3:0]            right_q;
    logic                  win_l_q;
    logic                  win_r_q;
    logic                  over_q;
    logic                  winner_q;
    logic                  prev_l;
    logic                  prev_r;
    logic [CW-1:0]         hold_q;

    logic                  p_l;
    logic                  p_r;
    logic                  mv_l;
    logic                  mv_r;
    logic [3:0]            left_next;
    logic [3:0]            right_next;
    logic [NUM_LIGHTS-1:0] disp_r;
    logic [NUM_LIGHTS-1:0] disp_l;
    logic [NUM_LIGHTS-1:0] disp_hold;

    always_comb begin
        p_l        = pf.L & ~prev_l;
        p_r        = pf.R & ~prev_r;
        mv_l       = p_l & ~p_r;
        mv_r       = p_r & ~p_l;
        left_next  = left_q + 4'd1;
        right_next = right_q + 4'd1;
    end

`ifdef TUG_END_FLASH_EN
    // Remembers which end to blink; the display toggles against it each cycle.
    logic [NUM_LIGHTS-1:0] end_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            end_mask <= '0;
        end else if (state == S_PLAY && mv_r && lights_q[0]) begin
            end_mask <= RIGHT_END;
        end else if (state == S_PLAY && mv_l && lights_q[NUM_LIGHTS-1]) begin
            end_mask <= LEFT_END;
        end
    end

    always_comb begin
        disp_r    = RIGHT_END;
        disp_l    = LEFT_END;
        disp_hold = lights_q ^ end_mask;
    end
`else
    always_comb begin
        disp_r    = '0;
        disp_l    = '0;
        disp_hold = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_PLAY;
            lights_q <= CENTRE;
            left_q   <= '0;
            right_q  <= '0;
            win_l_q  <= 1'b0;
            win_r_q  <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
            prev_l   <= 1'b1;
            prev_r   <= 1'b1;
            hold_q   <= '0;
        end else begin
            prev_l  <= pf.L;
            prev_r  <= pf.R;
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
            case (state)
                S_PLAY: begin
                    if (mv_r) begin
                        if (lights_q[0]) begin
                            right_q  <= right_next;
                            win_r_q  <= 1'b1;
                            lights_q <= disp_r;
                            hold_q   <= '0;
                            if (right_next == WIN) begin
                                state    <= S_MATCH_OVER;
                                over_q   <= 1'b1;
                                winner_q <= 1'b1;
                            end else begin
                                state <= S_ROUND_END;
                            end
                        end else begin
                            lights_q <= lights_q >> 1;
                        end
                    end else if (mv_l) begin
                        if (lights_q[NUM_LIGHTS-1]) begin
                            left_q   <= left_next;
                            win_l_q  <= 1'b1;
                            lights_q <= disp_l;
                            hold_q   <= '0;
                            if (left_next == WIN) begin
                                state    <= S_MATCH_OVER;
                                over_q   <= 1'b1;
                                winner_q <= 1'b0;
                            end else begin
                                state <= S_ROUND_END;
                            end
                        end else begin
                            lights_q <= lights_q << 1;
                        end
                    end
                end
                S_ROUND_END: begin
                    if (hold_q == HOLD_LAST) begin
                        state    <= S_PLAY;
                        lights_q <= CENTRE;
                        hold_q   <= '0;
                    end else begin
                        hold_q   <= hold_q + 1'b1;
                        lights_q <= disp_hold;
                    end
                end
                S_MATCH_OVER: begin
                    lights_q <= disp_hold;
                end
                default: begin
                    state    <= S_PLAY;
                    lights_q <= CENTRE;
                    hold_q   <= '0;
                end
            endcase
        end
    end

    assign pf.lights       = lights_q;
    assign pf.left_score   = left_q;
    assign pf.right_score  = right_q;
    assign pf.round_win_l  = win_l_q;
    assign pf.round_win_r  = win_r_q;
    assign pf.match_over   = over_q;
    assign pf.match_winner = winner_q;
endmodule
